// File: rtl/red_pkg.sv
// Shared types and widths for the RED nibble-reduction sequencer.
// Consumers: nib_add4, red_seq (optional saturation via RED_SAT_EN).
package red_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NIB,
    ACC
  } red_state_t;

  localparam int NIB_W  = 4;
  localparam int PSUM_W = 5;
  localparam int RAW_W  = 7;
  localparam int WORD_W = 16;

  function automatic logic [NIB_W-1:0] nib_sel(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        i
  );
    return w[{i, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/nib_add4.sv
// 4-bit unsigned nibble adder with carry-out.
// Shared lane adder of the RED sequencer.
module nib_add4
  import red_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] s,
  output logic             g
);

  assign {g, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/red_seq.sv
// Multi-cycle RED sequencer: LANES nibble pairs per cycle, then accumulate.
// Define RED_SAT_EN to saturate overflowing results to +63.
module red_seq
  import red_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              ovf
);

  red_state_t        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] op_a_q, op_a_d;
  logic [WORD_W-1:0] op_b_q, op_b_d;
  logic [PSUM_W-1:0] p_q [4];
  logic [PSUM_W-1:0] p_d [4];
  logic [WORD_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [NIB_W-1:0]  la [LANES];
  logic [NIB_W-1:0]  lb [LANES];
  logic [NIB_W-1:0]  ls [LANES];
  logic              lg [LANES];
  logic [RAW_W-1:0]  raw;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      la[l] = nib_sel(op_a_q, 2'(idx_q + 3'(l)));
      lb[l] = nib_sel(op_b_q, 2'(idx_q + 3'(l)));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    nib_add4 u_add (
      .a (la[l]),
      .b (lb[l]),
      .s (ls[l]),
      .g (lg[l])
    );
  end

  assign raw = RAW_W'(p_q[0]) + RAW_W'(p_q[1])
             + RAW_W'(p_q[2]) + RAW_W'(p_q[3]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    p_d      = p_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = A;
          op_b_d  = B;
          idx_d   = '0;
          state_d = NIB;
        end
      end
      NIB: begin
        for (int l = 0; l < LANES; l++) begin
          p_d[2'(idx_q + 3'(l))] = {lg[l], ls[l]};
        end
        idx_d = idx_q + 3'(LANES);
        if (idx_d == 3'd4) state_d = ACC;
      end
      ACC: begin
`ifdef RED_SAT_EN
        result_d = raw[RAW_W-1] ? WORD_W'(16'h003F)
                                : WORD_W'(raw);
`else
        result_d = {{(WORD_W-RAW_W){raw[RAW_W-1]}}, raw};
`endif
        ovf_d   = raw[RAW_W-1];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      p_q      <= p_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_red_seq.sv
// Directed bench for red_seq at LANES=1,2,4 side by side.
// Expected results are hand-computed; RED_SAT_EN selects the saturated form.
module tb_red_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] res_v   [3];
  logic        ovf_v   [3];

  always #5 clk = ~clk;

  red_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .A(a_v[0]), .B(b_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(res_v[0]), .ovf(ovf_v[0]));
  red_seq #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .A(a_v[1]), .B(b_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(res_v[1]), .ovf(ovf_v[1]));
  red_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .A(a_v[2]), .B(b_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .result(res_v[2]), .ovf(ovf_v[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res_wrap;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int k,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lanes=%0d: got %h want %h",
                  nm, 1 << k, act, exp);
  endtask

  function automatic int lat(input int k);
    return 4 / (1 << k) + 1;
  endfunction

  function automatic logic [15:0] exp_res(input logic [15:0] w,
                                          input logic o);
`ifdef RED_SAT_EN
    return o ? 16'h003F : w;
`else
    if (o) return w;
    return w;
`endif
  endfunction

  // Called and returns at a negedge; done_edge=-1 if no done pulse seen.
  task automatic run(input int k, input logic [15:0] a,
                     input logic [15:0] b, input bit repulse,
                     output int done_edge, output int busy_cnt);
    start_v[k] = 1'b1;
    a_v[k] = a;
    b_v[k] = b;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    a_v[k] = 16'($urandom);
    b_v[k] = 16'($urandom);
    busy_cnt = int'(busy_v[k]);
    done_edge = -1;
    for (int e = 1; e <= lat(k) + 3; e++) begin
      if (repulse && e == 2) begin
        start_v[k] = 1'b1;
        a_v[k] = 16'hFFFF;
      end
      @(posedge clk);
      @(negedge clk);
      if (repulse && e == 2) start_v[k] = 1'b0;
      if (done_v[k]) begin
        done_edge = e;
        break;
      end
      busy_cnt += int'(busy_v[k]);
    end
  endtask

  initial begin
    int de, bc, seen;
    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{16'h1111, 16'h2222, 16'h000C, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFF8, 1'b1};
    vecs[3] = '{16'h8421, 16'h0000, 16'h000F, 1'b0};
    vecs[4] = '{16'hF0F0, 16'hF0F0, 16'h003C, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h003D, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h1111, 16'hFFC0, 1'b1};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 16'(busy_v[k]), 16'h0);
      chk("rst_done", k, 16'(done_v[k]), 16'h0);
      chk("rst_result", k, res_v[k], 16'h0000);
      chk("rst_ovf", k, 16'(ovf_v[k]), 16'h0);
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        run(k, vecs[i].a, vecs[i].b, 1'b0, de, bc);
        chk("latency", k, 16'(de), 16'(lat(k)));
        chk("busy_cycles", k, 16'(bc), 16'(lat(k)));
        chk("done_busy", k, 16'(busy_v[k]), 16'h0);
        chk("result", k, res_v[k],
            exp_res(vecs[i].res_wrap, vecs[i].ovf));
        chk("ovf", k, 16'(ovf_v[k]), 16'(vecs[i].ovf));
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", k, 16'(done_v[k]), 16'h0);
        chk("result_held", k, res_v[k],
            exp_res(vecs[i].res_wrap, vecs[i].ovf));
      end
    end

    for (int k = 0; k < 3; k++) begin
      run(k, 16'h8421, 16'h0000, 1'b1, de, bc);
      chk("repulse_latency", k, 16'(de), 16'(lat(k)));
      chk("repulse_result", k, res_v[k], 16'h000F);
      run(k, 16'h0001, 16'h0001, 1'b0, de, bc);
      chk("b2b_latency", k, 16'(de), 16'(lat(k)));
      chk("b2b_result", k, res_v[k], 16'h0002);

      start_v[k] = 1'b1;
      a_v[k] = 16'h1111;
      b_v[k] = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      start_v[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", k, 16'(busy_v[k]), 16'h0);
      chk("midrst_done", k, 16'(done_v[k]), 16'h0);
      chk("midrst_result", k, res_v[k], 16'h0000);
      seen = 0;
      repeat (6) begin
        @(posedge clk);
        @(negedge clk);
        seen += int'(done_v[k]);
      end
      chk("midrst_no_done", k, 16'(seen), 16'h0);
      run(k, 16'h1111, 16'h2222, 1'b0, de, bc);
      chk("post_rst_latency", k, 16'(de), 16'(lat(k)));
      chk("post_rst_result", k, res_v[k], 16'h000C);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
